// File: rtl/mem_bus_bridge.sv
// mem_bus_bridge: MEM-stage load/store to request/acknowledge bus bridge with interrupt synchroniser.
// Optional bus timeout abort enabled by defining MEM_BUS_TIMEOUT_EN.
module mem_bus_bridge #(
  parameter int NIRQ           = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            req_rd,
  input  logic            req_wr,
  input  logic [1:0]      size,
  input  logic            sext,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     DR,
  output logic            keep,
  output logic            IntReq_M,
  output logic            exc_adel,
  output logic            exc_ades,
  output logic            bus_err,
  output logic            bus_req,
  output logic            bus_we,
  output logic [31:0]     bus_addr,
  output logic [3:0]      bus_be,
  output logic [31:0]     bus_wdata,
  input  logic [31:0]     bus_rdata,
  input  logic            bus_ack,
  input  logic [NIRQ-1:0] irq_in
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  state_t state, state_n;
  logic req, aligned, start, misal, expire;
  logic [1:0] off_q, size_q;
  logic sext_q;
  logic [31:0] dr_q, sh, ext, wrep;
  logic [3:0] be;
  logic [NIRQ-1:0] s1, s2;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range");
  end
  assign req     = (req_rd | req_wr) & ~clr;
  assign aligned = size == 2'd0 ? 1'b1 : size == 2'd1 ? ~addr[0] : addr[1:0] == 2'd0;
  assign start   = state == IDLE && req && aligned;
  assign misal   = state == IDLE && req && !aligned;
  assign be      = size == 2'd0 ? 4'b0001 << addr[1:0] : size == 2'd1 ? 4'b0011 << addr[1:0] : 4'hF;
  assign wrep    = size == 2'd0 ? {4{wdata[7:0]}} : size == 2'd1 ? {2{wdata[15:0]}} : wdata;
  assign sh      = bus_rdata >> {off_q, 3'b000};
  assign ext     = size_q == 2'd0 ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                   size_q == 2'd1 ? {{16{sext_q & sh[15]}}, sh[15:0]} : bus_rdata;
  assign DR      = misal ? '0 : dr_q;
`ifdef MEM_BUS_TIMEOUT_EN
  logic [15:0] cnt;
  assign expire = state == WAIT && !bus_ack && cnt == 16'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk)
    if (rst || state != WAIT) cnt <= '0;
    else if (!bus_ack) cnt <= cnt + 16'd1;
  always_ff @(posedge clk) bus_err <= rst ? 1'b0 : expire;
`else
  assign expire  = 1'b0;
  assign bus_err = 1'b0;
`endif
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb
    state_n = state == IDLE ? (start ? WAIT : IDLE) :
              state == WAIT ? (bus_ack || expire ? DONE : WAIT) : IDLE;
  always_comb begin
    keep     = start || state == WAIT;
    exc_adel = misal && req_rd;
    exc_ades = misal && req_wr && !req_rd;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_be    <= '0;
      bus_wdata <= '0;
      off_q     <= '0;
      size_q    <= '0;
      sext_q    <= 1'b0;
      dr_q      <= '0;
    end else if (start) begin
      bus_req   <= 1'b1;
      bus_we    <= req_wr;
      bus_addr  <= {addr[31:2], 2'b00};
      bus_be    <= be;
      bus_wdata <= req_wr ? wrep : '0;
      off_q     <= addr[1:0];
      size_q    <= size;
      sext_q    <= sext;
    end else if (state == WAIT && (bus_ack || expire)) begin
      bus_req <= 1'b0;
      dr_q    <= bus_ack ? ext : '0;
    end else if (misal) dr_q <= '0;
  always_ff @(posedge clk)
    if (rst) begin
      s1       <= '0;
      s2       <= '0;
      IntReq_M <= 1'b0;
    end else begin
      s1       <= irq_in;
      s2       <= s1;
      IntReq_M <= |s2;
    end
endmodule

// File: doc/mem_bus_bridge.md
Name: mem_bus_bridge

Overview:
- MEM-stage producer for the MEM/WB pipeline register: the writer side of the DR, keep and IntReq_M signals that register latches.
- Turns a MEM-stage load/store into a multi-cycle request/acknowledge transaction on the system bus (data memory plus FPGA peripherals).
- Holds the pipeline with keep until the transaction completes, then presents lane-aligned, extended load data on DR.
- Synchronises external device interrupt lines into IntReq_M.

Parameters:
- NIRQ, 6, number of external interrupt lines.
- TIMEOUT_CYCLES, 255, WAIT-state cycles without bus_ack before abort; valid range 1..65535.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clr  in  1  MEM-stage flush; suppresses starting a new access.
- req_rd  in  1  MEM-stage instruction is a load.
- req_wr  in  1  MEM-stage instruction is a store.
- size  in  2  access size: 0 byte, 1 half, 2 word; 3 is treated as word.
- sext  in  1  sign-extend load data.
- addr  in  32  effective address (AO).
- wdata  in  32  store data, right-aligned.
- DR  out  32  extended load data, to MEM/WB.
- keep  out  1  pipeline hold.
- IntReq_M  out  1  interrupt request, to MEM/WB.
- exc_adel  out  1  misaligned load.
- exc_ades  out  1  misaligned store.
- bus_err  out  1  timeout abort.
- bus_req  out  1  bus request.
- bus_we  out  1  bus write.
- bus_addr  out  32  word address; bits 1:0 are always 0.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data.
- bus_ack  in  1  transfer complete, 1-cycle pulse.
- irq_in  in  NIRQ  asynchronous device interrupts, active-high.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, timeout counter 0, irq synchronisers 0.
- Reset mid-transaction aborts locally with no further bus activity; an ack arriving after reset is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, with (req_rd|req_wr) & ~clr & aligned:
  - keep=1 combinationally.
  - Next cycle: WAIT, with bus_req=1 and bus_we/bus_addr/bus_be/bus_wdata registered from the inputs.
- IDLE, misaligned request (half with addr[0]=1, or word with addr[1:0]≠0):
  - no bus access, keep=0.
  - exc_adel (load) or exc_ades (store) =1 combinationally for that cycle.
  - DR=0.
- IDLE, with clr=1 or no request: keep=0, stay in IDLE.
- WAIT:
  - keep=1; bus outputs held stable.
  - On bus_ack: latch bus_rdata, drop bus_req, go to DONE.
  - clr during WAIT does not cancel the bus transfer; it completes normally.
- DONE:
  - keep=0 for exactly one cycle; DR valid so MEM/WB captures it at this clock edge.
  - The still-asserted request of the same instruction is ignored.
  - Next state IDLE.
- Minimum load/store latency: 2 stall cycles (ack in the first WAIT cycle).
- Store lanes:
  - byte: bus_be=1<<addr[1:0], wdata[7:0] replicated to all 4 lanes.
  - half: bus_be=4'b0011<<addr[1:0], wdata[15:0] replicated to both halves.
  - word: bus_be=4'hF.
- Read requests: bus_be as for stores, bus_wdata=0.
- Load extract: lane selected by addr[1:0] registered at request; zero- or sign-extended per sext; word loads pass through unchanged.
- DR is held between accesses and updates only in DONE or on misalignment (forced 0).
- IntReq_M: each irq_in bit passes through a 2-flop synchroniser, the bits are ORed, and the OR is registered. Latency from irq_in rising to IntReq_M = 3 cycles. IntReq_M is independent of FSM state and keep.
- A bus_ack outside WAIT is ignored.

Optional Feature:
- Macro: MEM_BUS_TIMEOUT_EN.
- Defined:
  - 16-bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - At count == TIMEOUT_CYCLES-1 with no ack: drop bus_req, DR=0, bus_err=1 for the DONE cycle, then IDLE.
  - Ack in the same cycle as expiry wins; no error.
- Undefined: no counter, WAIT persists until bus_ack, bus_err tied 0.

Test Plan:
- Word load, addr=0x0000_1004, bus_rdata=0x1234_5678, ack in 1st WAIT cycle -> keep high 2 cycles, bus_be=4'hF, bus_addr=0x1004, DR=0x1234_5678 in DONE.
- Byte load, addr=0x...03, sext=1, bus_rdata=0x80AA_BBCC -> DR=0xFFFF_FF80; with sext=0 -> DR=0x0000_0080.
- Half store, addr=0x...02, wdata=0x0000_BEEF -> bus_we=1, bus_be=4'b1100, bus_wdata=0xBEEF_BEEF; ack after 5 WAIT cycles -> keep high 6 cycles.
- Word load at addr=0x...02 -> exc_adel=1 one cycle, no bus_req, keep=0, DR=0; store with clr=1 -> no bus_req.
- irq_in[3] pulses high 4 cycles -> IntReq_M rises 3 cycles later, falls 3 cycles after irq_in drops; rst asserted in WAIT -> bus_req=0 next cycle, IDLE.
- MEM_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 WAIT cycles, bus_err=1 and DR=0 in DONE, keep low; ack on 4th WAIT cycle -> bus_err=0.
